pipe_sqrt_csla: RTL and testbench
=================================

PIPE_SQRT_CSLA -- requirements
Module: pipe_sqrt_csla

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high (clk, rst).
REQ-002 Parameter SHALL be: WIDTH, 32, operand/result width in bits (8..64).
REQ-003 Parameter SHALL be: STAGES, 2, number of pipeline register stages (1..4); WIDTH SHALL be divisible by STAGES.
REQ-004 Port SHALL be: clk  input  1  rising-edge clock.
REQ-005 Port SHALL be: rst  input  1  synchronous active-high reset.
REQ-006 Port SHALL be: in_valid  input  1  operand beat present.
REQ-007 Port SHALL be: in_ready  output  1  block accepts a beat this cycle.
REQ-008 Port SHALL be: x  input  WIDTH  operand A.
REQ-009 Port SHALL be: y  input  WIDTH  operand B.
REQ-010 Port SHALL be: cin  input  1  carry-in (add) or borrow-in (subtract).
REQ-011 Port SHALL be: sub  input  1  0 = add, 1 = subtract.
REQ-012 Port SHALL be: out_valid  output  1  result beat present.
REQ-013 Port SHALL be: out_ready  input  1  downstream accepts the result.
REQ-014 Port SHALL be: s  output  WIDTH  sum/difference.
REQ-015 Port SHALL be: cout  output  1  carry-out (add) or not-borrow (subtract).
REQ-016 Port SHALL be: ovf  output  1  two's-complement signed overflow.

Function
REQ-017 Effective operands SHALL be b = y XOR {WIDTH{sub}} and c0 = cin XOR sub; result {cout,s} = x + b + c0 (sub=1 gives x - y - cin).
REQ-018 ovf SHALL be 1 iff x[MSB] == b[MSB] and s[MSB] != x[MSB].
REQ-019 The datapath SHALL be split into STAGES equal slices of WIDTH/STAGES bits; slice k SHALL be computed in pipeline stage k, with the slice carry registered into stage k+1 and the not-yet-added upper operand bits and completed lower sum bits carried forward in registers.
REQ-020 Each slice SHALL be a square-root carry-select adder: group sizes 2,2,3,4,5,... (last group truncated to fit); group 0 ripple/CLA with true carry-in, later groups compute the cin=0 sum and derive the cin=1 sum with a binary-to-excess-1 converter, muxed by the incoming group carry.
REQ-021 Latency SHALL be exactly STAGES clock cycles from an accepted input beat (in_valid & in_ready) to the corresponding out_valid, when no stall occurs.
REQ-022 Pipeline advance enable SHALL be en = ~out_valid | out_ready; in_ready SHALL equal en (combinational, rst excluded).
REQ-023 When en=0 all stage registers, s, cout, ovf, out_valid SHALL hold; beats SHALL NOT be dropped or duplicated.
REQ-024 Throughput SHALL be one beat per cycle with out_ready held at 1; results SHALL exit in acceptance order.
REQ-025 Empty slots (in_valid=0 while en=1) SHALL propagate as bubbles; bubbles SHALL NOT be collapsed.
REQ-026 A result SHALL be consumed on a cycle with out_valid & out_ready; a simultaneous new beat entering stage 1 on that cycle SHALL be accepted.

Reset
REQ-027 While rst=1 at a clock edge, all stage valid bits, out_valid, s, cout and ovf SHALL become 0 on that edge.
REQ-028 Reset mid-operation SHALL discard all in-flight beats; no pre-reset beat SHALL ever appear at the output.
REQ-029 Inputs presented in the cycle rst=1 SHALL NOT be accepted.

Verification (WIDTH=32, STAGES=2, out_ready=1 unless stated)
REQ-030 x=42884743, y=42884743, cin=0, sub=0 -> 2 cycles later out_valid=1, s=85108E86, cout=0, ovf=1.
REQ-031 x=F28A47B3, y=4B8B47A3, cin=1, sub=0 -> s=3E158F57, cout=1, ovf=0.
REQ-032 x=00000005, y=00000007, cin=0, sub=1 -> s=FFFFFFFE, cout=0, ovf=0; and x=80000000, y=00000001, cin=0, sub=1 -> s=7FFFFFFF, cout=1, ovf=1.
REQ-033 Three back-to-back beats with out_ready=0 for 3 cycles once out_valid=1 -> in_ready=0, s/cout/ovf stable during stall; after release all three results appear in order on consecutive cycles.
REQ-034 rst asserted for 1 cycle with 2 beats in flight -> next cycle out_valid=0, s=0, cout=0, ovf=0; no stale result emerges afterwards.
REQ-035 Random 10k beats with random in_valid/out_ready, all STAGES values 1..4 and WIDTH 8/32/64 -> every result matches REQ-017/018 reference model, order preserved.

Source files
------------

// File: rtl/pipe_sqrt_csla.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_sqrt_csla
//  Description : Pipelined add/subtract unit. The operand width is split into
//                STAGES equal slices. Each slice is summed in its own pipeline
//                stage by a square-root carry-select adder. Group sizes are
//                2,2,3,4,5,... and each upper group uses a binary-to-excess-1
//                converter to produce its carry-in=1 sum. The pipeline uses
//                valid/ready flow control and stalls globally.
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  pipe_sqrt_csla_slice : one W-bit square-root carry-select adder slice
// ----------------------------------------------------------------------------
module pipe_sqrt_csla_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co
);

    // Bit position where group g starts (group sizes 2,2,3,4,5,...)
    function automatic int f_gstart(input int g);
        int p;
        p = 0;
        for (int i = 0; i < g; i++) begin
            p = p + ((i < 2) ? 2 : i + 1);
        end
        return p;
    endfunction

    // Number of groups needed to cover w bits (last group truncated)
    function automatic int f_ngroups(input int w);
        int n;
        n = 0;
        for (int i = 0; i <= w; i++) begin
            if (f_gstart(i) < w) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

    localparam int c_NG = f_ngroups(W);

    // Carry entering each group; the last entry is the slice carry-out
    logic [c_NG:0] w_gc;

    assign w_gc[0] = ci;
    assign co      = w_gc[c_NG];

    generate
        for (genvar g = 0; g < c_NG; g++) begin : g_grp
            localparam int c_LO = f_gstart(g);
            localparam int c_HI = (f_gstart(g + 1) < W) ? f_gstart(g + 1) : W;
            localparam int c_N  = c_HI - c_LO;

            if (g == 0) begin : g_first
                // First group adds directly with the true slice carry-in
                logic [c_N:0] w_r;
                assign w_r = {1'b0, a[c_HI-1:c_LO]} + {1'b0, b[c_HI-1:c_LO]}
                           + {{c_N{1'b0}}, w_gc[0]};
                assign sum[c_HI-1:c_LO] = w_r[c_N-1:0];
                assign w_gc[1]          = w_r[c_N];
            end else begin : g_sel
                logic [c_N:0] w_s0;
                logic [c_N:0] w_s1;

                // Speculative sum assuming the incoming group carry is 0
                assign w_s0 = {1'b0, a[c_HI-1:c_LO]} + {1'b0, b[c_HI-1:c_LO]};

                // Binary-to-excess-1: w_s1 = w_s0 + 1 (a bit flips when all lower bits are 1)
                always_comb begin : bec
                    logic w_t;
                    w_s1 = '0;
                    w_t  = 1'b1;
                    for (int i = 0; i <= c_N; i++) begin
                        w_s1[i] = w_s0[i] ^ w_t;
                        w_t     = w_t & w_s0[i];
                    end
                end

                // The real group carry picks between the two precomputed sums
                assign {w_gc[g+1], sum[c_HI-1:c_LO]} = w_gc[g] ? w_s1 : w_s0;
            end
        end
    endgenerate

endmodule

// ----------------------------------------------------------------------------
//  pipe_sqrt_csla : top level pipeline
// ----------------------------------------------------------------------------
module pipe_sqrt_csla #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int c_SW = WIDTH / STAGES;

    logic             w_en;
    logic [WIDTH-1:0] w_b0;
    logic             w_c0;

    // Every stage advances together; a full output that is not taken freezes the pipe
    assign w_en     = ~out_valid | out_ready;
    assign in_ready = w_en;

    // Subtraction becomes addition of the inverted operand with an inverted carry
    assign w_b0 = y ^ {WIDTH{sub}};
    assign w_c0 = cin ^ sub;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            localparam int c_LO = k * c_SW;
            localparam int c_HI = c_LO + c_SW;

            // Operand bits not yet summed, incoming carry and slot valid
            logic [WIDTH-1:c_LO] w_xi;
            logic [WIDTH-1:c_LO] w_bi;
            logic                w_ci;
            logic                w_vi;
            // This slice's sum and the sum completed so far, including this slice
            logic [c_SW-1:0]     w_sum;
            logic                w_co;
            logic [c_HI-1:0]     w_so;
            // Stage registers
            logic [c_HI-1:0]     r_s;
            logic                r_c;
            logic                r_v;

            if (k == 0) begin : g_head
                assign w_xi = x;
                assign w_bi = w_b0;
                assign w_ci = w_c0;
                assign w_vi = in_valid;
                assign w_so = w_sum;
            end else begin : g_body
                assign w_xi = g_stage[k-1].g_fwd.r_x;
                assign w_bi = g_stage[k-1].g_fwd.r_b;
                assign w_ci = g_stage[k-1].r_c;
                assign w_vi = g_stage[k-1].r_v;
                assign w_so = {w_sum, g_stage[k-1].r_s};
            end

            pipe_sqrt_csla_slice #(
                .W (c_SW)
            ) u_slice (
                .a   (w_xi[c_HI-1:c_LO]),
                .b   (w_bi[c_HI-1:c_LO]),
                .ci  (w_ci),
                .sum (w_sum),
                .co  (w_co)
            );

            if (k < STAGES - 1) begin : g_fwd
                logic [WIDTH-1:c_HI] r_x;
                logic [WIDTH-1:c_HI] r_b;

                // Carry the operand bits the later slices still need
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_x <= '0;
                        r_b <= '0;
                    end else if (w_en) begin
                        r_x <= w_xi[WIDTH-1:c_HI];
                        r_b <= w_bi[WIDTH-1:c_HI];
                    end
                end
            end else begin : g_tail
                logic r_ovf;

                // Signed overflow: operands share a sign but the result sign differs
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_ovf <= 1'b0;
                    end else if (w_en) begin
                        r_ovf <= (w_xi[WIDTH-1] == w_bi[WIDTH-1]) &
                                 (w_sum[c_SW-1] != w_xi[WIDTH-1]);
                    end
                end
            end

            // Register the partial sum, the slice carry and the slot valid bit
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s <= '0;
                    r_c <= 1'b0;
                    r_v <= 1'b0;
                end else if (w_en) begin
                    r_s <= w_so;
                    r_c <= w_co;
                    r_v <= w_vi;
                end
            end
        end
    endgenerate

    assign s         = g_stage[STAGES-1].r_s;
    assign cout      = g_stage[STAGES-1].r_c;
    assign out_valid = g_stage[STAGES-1].r_v;
    assign ovf       = g_stage[STAGES-1].g_tail.r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_pipe_sqrt_csla.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_sqrt_csla
//  Description : Self-checking bench for pipe_sqrt_csla (WIDTH=32, STAGES=2)
//                with an arithmetic reference model and an in-order queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_sqrt_csla;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             ovf;
    } res_t;

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             cin;
        logic             sub;
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             ovf;
    } vec_t;

    res_t q[$];
    int   total = 0;
    int   bad   = 0;

    pipe_sqrt_csla #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: exact integer add/subtract, then judge wrap, carry and signed range
    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] bv,
                                   input logic ci, input logic sb);
        res_t   r;
        longint ua, ub, sa, sbv, cc, uu, ss, lim, smax, smin;
        ua   = {{(64-WIDTH){1'b0}}, a};
        ub   = {{(64-WIDTH){1'b0}}, bv};
        sa   = {{(64-WIDTH){a[WIDTH-1]}}, a};
        sbv  = {{(64-WIDTH){bv[WIDTH-1]}}, bv};
        cc   = ci ? 64'sd1 : 64'sd0;
        lim  = 64'sd1 <<< WIDTH;
        smax = (64'sd1 <<< (WIDTH - 1)) - 64'sd1;
        smin = -(64'sd1 <<< (WIDTH - 1));
        if (!sb) begin
            uu     = ua + ub + cc;
            ss     = sa + sbv + cc;
            r.cout = (uu >= lim);
        end else begin
            uu     = ua - ub - cc;
            ss     = sa - sbv - cc;
            r.cout = (ua >= ub + cc);
        end
        r.s   = uu[WIDTH-1:0];
        r.ovf = (ss > smax) || (ss < smin);
        return r;
    endfunction

    // Random operands with occasional corner values
    task automatic rand_operands();
        logic [WIDTH-1:0] corner [4];
        corner[0] = '0;
        corner[1] = '1;
        corner[2] = {1'b1, {(WIDTH-1){1'b0}}};
        corner[3] = {1'b0, {(WIDTH-1){1'b1}}};
        x   = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
        y   = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
        cin = ($urandom_range(0, 1) != 0);
        sub = ($urandom_range(0, 1) != 0);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        rand_operands();
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++; if (s !== '0) begin bad++; $display("FAIL reset_s: got %h want 0", s); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b want 0", cout); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int n = 0; n < STAGES + 2; n++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_accept: got out_valid %b want 0", out_valid); end
        end
    endtask

    task automatic test_vectors();
        vec_t tv [4];
        int   lat;
        tv[0] = '{x:32'h42884743, y:32'h42884743, cin:1'b0, sub:1'b0, s:32'h85108E86, cout:1'b0, ovf:1'b1};
        tv[1] = '{x:32'hF28A47B3, y:32'h4B8B47A3, cin:1'b1, sub:1'b0, s:32'h3E158F57, cout:1'b1, ovf:1'b0};
        tv[2] = '{x:32'h00000005, y:32'h00000007, cin:1'b0, sub:1'b1, s:32'hFFFFFFFE, cout:1'b0, ovf:1'b0};
        tv[3] = '{x:32'h80000000, y:32'h00000001, cin:1'b0, sub:1'b1, s:32'h7FFFFFFF, cout:1'b1, ovf:1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            x        = tv[i].x;
            y        = tv[i].y;
            cin      = tv[i].cin;
            sub      = tv[i].sub;
            lat      = -1;
            for (int n = 1; n <= STAGES + 4; n++) begin
                @(posedge clk); #1;
                if (n == 1) in_valid = 1'b0;
                if (out_valid) begin
                    lat = n;
                    break;
                end
            end
            total++; if (lat != STAGES) begin bad++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, STAGES); end
            total++; if (s !== tv[i].s) begin bad++; $display("FAIL vec%0d_s: got %h want %h", i, s, tv[i].s); end
            total++; if (cout !== tv[i].cout) begin bad++; $display("FAIL vec%0d_cout: got %b want %b", i, cout, tv[i].cout); end
            total++; if (ovf !== tv[i].ovf) begin bad++; $display("FAIL vec%0d_ovf: got %b want %b", i, ovf, tv[i].ovf); end
        end
    endtask

    task automatic test_back_to_back();
        int   idx, popped, first;
        res_t e;
        q.delete();
        idx = 0; popped = 0; first = -1;
        for (int cyc = 0; cyc < 40 && popped < 8; cyc++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            in_valid  = (idx < 8);
            rand_operands();
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (first < 0) first = cyc;
                total++; if (cyc != first + popped) begin bad++; $display("FAIL b2b_gap: got cycle %0d want %0d", cyc, first + popped); end
                e = q.pop_front();
                total++; if ({s, cout, ovf} !== {e.s, e.cout, e.ovf}) begin
                    bad++; $display("FAIL b2b_result: got %h/%b/%b want %h/%b/%b", s, cout, ovf, e.s, e.cout, e.ovf);
                end
                popped++;
            end
            if (in_valid) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
                if (in_ready) begin
                    q.push_back(model(x, y, cin, sub));
                    idx++;
                end
            end
        end
        in_valid = 1'b0;
        total++; if (popped != 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", popped); end
    endtask

    task automatic test_stall();
        int   idx, popped, stall_left, last_pop;
        res_t e;
        q.delete();
        idx = 0; popped = 0; stall_left = -1; last_pop = -1;
        for (int cyc = 0; cyc < 40 && popped < 3; cyc++) begin
            @(posedge clk); #1;
            if (stall_left < 0 && out_valid) stall_left = 3;
            out_ready = !(stall_left > 0);
            in_valid  = (idx < 3);
            if (in_valid) rand_operands();
            @(negedge clk);
            if (stall_left > 0) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready: got %b want 0", in_ready); end
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b want 1", out_valid); end
                if (q.size() > 0) begin
                    total++; if ({s, cout, ovf} !== {q[0].s, q[0].cout, q[0].ovf}) begin
                        bad++; $display("FAIL stall_hold: got %h/%b/%b want %h/%b/%b", s, cout, ovf, q[0].s, q[0].cout, q[0].ovf);
                    end
                end
                stall_left--;
            end
            if (out_valid && out_ready) begin
                if (popped > 0) begin
                    total++; if (cyc != last_pop + 1) begin bad++; $display("FAIL stall_gap: got cycle %0d want %0d", cyc, last_pop + 1); end
                end
                total++; if (q.size() == 0) begin
                    bad++; $display("FAIL stall_extra: got unexpected result %h want none", s);
                end else begin
                    e = q.pop_front();
                    total++; if ({s, cout, ovf} !== {e.s, e.cout, e.ovf}) begin
                        bad++; $display("FAIL stall_result: got %h/%b/%b want %h/%b/%b", s, cout, ovf, e.s, e.cout, e.ovf);
                    end
                end
                last_pop = cyc;
                popped++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(x, y, cin, sub));
                idx++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++; if (popped != 3) begin bad++; $display("FAIL stall_count: got %0d want 3", popped); end
    endtask

    task automatic test_reset_flight();
        q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            rand_operands();
        end
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        rand_operands();
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        total++; if (s !== '0) begin bad++; $display("FAIL flush_s: got %h want 0", s); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL flush_cout: got %b want 0", cout); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL flush_ovf: got %b want 0", ovf); end
        for (int n = 0; n < STAGES + 3; n++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_stale: got out_valid %b want 0", out_valid); end
        end
    endtask

    task automatic test_random();
        res_t e;
        q.delete();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk); #1;
            if (cyc < 3500) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                rand_operands();
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            @(negedge clk);
            total++; if (in_ready !== (~out_valid | out_ready)) begin
                bad++; $display("FAIL rand_ready: got %b want %b", in_ready, ~out_valid | out_ready);
            end
            if (out_valid && out_ready) begin
                total++; if (q.size() == 0) begin
                    bad++; $display("FAIL rand_extra: got unexpected result %h want none", s);
                end else begin
                    e = q.pop_front();
                    total++; if ({s, cout, ovf} !== {e.s, e.cout, e.ovf}) begin
                        bad++; $display("FAIL rand_result: got %h/%b/%b want %h/%b/%b", s, cout, ovf, e.s, e.cout, e.ovf);
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(model(x, y, cin, sub));
        end
        total++; if (q.size() != 0) begin bad++; $display("FAIL rand_drain: got %0d pending want 0", q.size()); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        x         = '0;
        y         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_stall();
        test_reset_flight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
